// File: rtl/ghash_pkg.sv
// ghash_pkg: shared state encoding, byte padding mask and GF(2^128) reduction constant for the GHASH path.
package ghash_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_ISSUE, S_ISSUE_LEN, S_WAIT, S_WAIT_LEN, S_DONE, S_DRAIN
  } state_t;
  localparam logic [127:0] GF_R = 128'hE1 << 120;
  function automatic logic [127:0] pad_mask(input logic [4:0] bytes);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[127-8*i -: 8] = (i < int'(bytes)) ? 8'hFF : 8'h00;
    return m;
  endfunction
endpackage

// File: rtl/ghash_pad.sv
// ghash_pad: zero-pads a MSB-aligned partial block and flags byte counts outside 1..16.
module ghash_pad
  import ghash_pkg::*;
(
  input  logic [127:0] i_data,
  input  logic [4:0]   i_bytes,
  output logic [127:0] o_x,
  output logic         o_bad
);
  assign o_x   = i_data & pad_mask(i_bytes);
  assign o_bad = (i_bytes == 5'd0) || (i_bytes > 5'd16);
endmodule

// File: rtl/ghash_ctrl.sv
// ghash_ctrl: GHASH sequencer driving an external multiply-by-H unit; optional GHASH_TAG_MASK_EN
// adds a tag_mask port that is XORed into the final tag.
module ghash_ctrl
  import ghash_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [127:0] h_key,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  input  logic [4:0]   blk_bytes,
  input  logic         blk_is_aad,
  input  logic         fin,
`ifdef GHASH_TAG_MASK_EN
  input  logic [127:0] tag_mask,
`endif
  output logic         mul_start,
  output logic [127:0] mul_h,
  output logic [127:0] mul_block,
  input  logic [127:0] mul_result,
  input  logic         mul_ready,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         error
);
  state_t             r_state, w_next;
  logic [127:0]       r_y, r_h, r_mul_block, r_tag;
  logic [LEN_W-1:0]   r_aad_len, r_txt_len;
  logic               r_fin_pend, r_seen_c, r_tag_valid, r_error;
  logic [127:0]       w_x, w_tag_val;
  logic [LEN_W-1:0]   w_inc;
  logic               w_pad_bad, w_bad, w_accept, w_fin_go, w_outstanding;

  ghash_pad u_pad (.i_data(blk_data), .i_bytes(blk_bytes), .o_x(w_x), .o_bad(w_pad_bad));

`ifdef GHASH_TAG_MASK_EN
  assign w_tag_val = mul_result ^ tag_mask;
`else
  assign w_tag_val = mul_result;
`endif

  assign w_inc         = LEN_W'({blk_bytes, 3'b000});
  assign w_bad         = w_pad_bad || (blk_is_aad && r_seen_c);
  assign w_accept      = (r_state == S_READY) && blk_valid && !init;
  assign w_fin_go      = (r_state == S_READY) && !blk_valid && (fin || r_fin_pend) && !init;
  // A multiply is still in flight unless its completion pulse is arriving this cycle.
  assign w_outstanding = (r_state inside {S_ISSUE, S_ISSUE_LEN}) ||
                         ((r_state inside {S_WAIT, S_WAIT_LEN, S_DRAIN}) && !mul_ready);

  always_comb begin
    w_next = r_state;
    if (init) w_next = w_outstanding ? S_DRAIN : S_READY;
    else
      case (r_state)
        S_READY:     w_next = w_accept ? (w_bad ? S_READY : S_ISSUE) : (w_fin_go ? S_ISSUE_LEN : S_READY);
        S_ISSUE:     w_next = S_WAIT;
        S_ISSUE_LEN: w_next = S_WAIT_LEN;
        S_WAIT:      w_next = mul_ready ? S_READY : S_WAIT;
        S_WAIT_LEN:  w_next = mul_ready ? S_DONE : S_WAIT_LEN;
        S_DRAIN:     w_next = mul_ready ? S_READY : S_DRAIN;
        default:     w_next = r_state;
      endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_y         <= '0;
      r_h         <= '0;
      r_mul_block <= '0;
      r_tag       <= '0;
      r_aad_len   <= '0;
      r_txt_len   <= '0;
      r_fin_pend  <= 1'b0;
      r_seen_c    <= 1'b0;
      r_tag_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (init) begin
        r_y         <= '0;
        r_h         <= h_key;
        r_tag       <= '0;
        r_aad_len   <= '0;
        r_txt_len   <= '0;
        r_fin_pend  <= 1'b0;
        r_seen_c    <= 1'b0;
        r_tag_valid <= 1'b0;
        r_error     <= 1'b0;
      end else begin
        if (fin && r_state != S_DONE && (r_state != S_READY || w_accept)) r_fin_pend <= 1'b1;
        else if (w_fin_go) r_fin_pend <= 1'b0;
        if (w_accept && w_bad) r_error <= 1'b1;
        if (w_accept && !w_bad) begin
          r_mul_block <= r_y ^ w_x;
          if (blk_is_aad) r_aad_len <= r_aad_len + w_inc;
          else begin
            r_txt_len <= r_txt_len + w_inc;
            r_seen_c  <= 1'b1;
          end
        end
        if (w_fin_go) r_mul_block <= r_y ^ {64'(r_aad_len), 64'(r_txt_len)};
        if (r_state == S_WAIT && mul_ready) r_y <= mul_result;
        if (r_state == S_WAIT_LEN && mul_ready) begin
          r_tag       <= w_tag_val;
          r_tag_valid <= 1'b1;
        end
      end
    end
  end

  assign blk_ready = r_state == S_READY;
  assign mul_start = r_state inside {S_ISSUE, S_ISSUE_LEN};
  assign mul_h     = r_h;
  assign mul_block = r_mul_block;
  assign tag       = r_tag;
  assign tag_valid = r_tag_valid;
  assign error     = r_error;
endmodule

// File: tb/tb_ghash_ctrl.sv
// tb_ghash_ctrl: ghash_ctrl paired with a behavioural multiply-by-H unit and a scoreboard GHASH model.
module tb_ghash_ctrl;
  import ghash_pkg::*;
  logic clk = 0, reset_n = 0, init = 0, blk_valid = 0, blk_is_aad = 0, fin = 0, mul_ready = 0;
  logic [127:0] h_key = '0, blk_data = '0, mul_result = '0, tag_mask = '0;
  logic [4:0] blk_bytes = '0;
  logic blk_ready, mul_start, tag_valid, error;
  logic [127:0] mul_h, mul_block, tag;

  ghash_ctrl dut (
    .clk(clk), .reset_n(reset_n), .init(init), .h_key(h_key), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .blk_bytes(blk_bytes), .blk_is_aad(blk_is_aad),
    .fin(fin),
`ifdef GHASH_TAG_MASK_EN
    .tag_mask(tag_mask),
`endif
    .mul_start(mul_start), .mul_h(mul_h), .mul_block(mul_block), .mul_result(mul_result),
    .mul_ready(mul_ready), .tag(tag), .tag_valid(tag_valid), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z ^= v;
      v = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Multiply-by-H unit: captures operand and H on start, answers after 1..4 cycles.
  logic busy = 0;
  int cnt = 0, n_starts = 0, lat_fix = 0;
  logic [127:0] bx, bh;
  initial forever begin
    @(posedge clk);
    #2;
    mul_ready = 0;
    if (busy) begin
      if (cnt == 0) begin
        mul_ready  = 1;
        mul_result = gf_mul(bx, bh);
        busy       = 0;
      end else cnt--;
    end
    if (mul_start) begin
      n_starts++;
      chk("start_while_busy", {127'b0, busy}, 128'd0);
      busy = 1;
      bx   = mul_block;
      bh   = mul_h;
      cnt  = (lat_fix > 0) ? lat_fix : int'($urandom_range(0, 3));
    end
  end

  // Reference model: list of padded blocks and bit lengths, hashed from scratch at fin.
  typedef struct {logic [127:0] tag; logic err;} exp_t;
  exp_t sb[$];
  logic [127:0] m_blocks[$];
  logic [127:0] m_h, m_mask;
  logic [63:0] m_alen, m_clen;
  logic m_seen_c, m_err;

  function automatic logic [127:0] model_tag();
    logic [127:0] y;
    y = '0;
    foreach (m_blocks[i]) y = gf_mul(y ^ m_blocks[i], m_h);
    return gf_mul(y ^ {m_alen, m_clen}, m_h) ^ m_mask;
  endfunction

  logic prev_tv = 0;
  always @(negedge clk) begin
    exp_t e;
    if (tag_valid && !prev_tv) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tag: got %h expected no tag", tag);
      end else begin
        e = sb.pop_front();
        chk("tag", tag, e.tag);
        chk("tag_error", {127'b0, error}, {127'b0, e.err});
      end
    end
    prev_tv = tag_valid;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [127:0] t);
    exp_t e;
    e.tag = t;
    e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic do_init(input logic [127:0] h, input logic [127:0] msk);
    init = 1;
    h_key = h;
    tag_mask = msk;
    cyc();
    init = 0;
    m_h = h;
`ifdef GHASH_TAG_MASK_EN
    m_mask = msk;
`else
    m_mask = '0;
`endif
    m_blocks.delete();
    m_alen = '0;
    m_clen = '0;
    m_seen_c = 0;
    m_err = 0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!blk_ready && k < 300) begin
      cyc();
      k++;
    end
    if (!blk_ready) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: blk_ready=0 after %0d cycles, required 1", k);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic [4:0] n, input logic aad, input logic with_fin);
    int sh;
    wait_ready();
    blk_valid = 1;
    blk_data = d;
    blk_bytes = n;
    blk_is_aad = aad;
    fin = with_fin;
    cyc();
    blk_valid = 0;
    fin = 0;
    if (n == 0 || n > 16 || (aad && m_seen_c)) m_err = 1;
    else begin
      sh = 8 * (16 - int'(n));
      m_blocks.push_back((d >> sh) << sh);
      if (aad) m_alen += 64'(8 * int'(n));
      else begin
        m_clen += 64'(8 * int'(n));
        m_seen_c = 1;
      end
    end
    if (with_fin) push_exp(model_tag());
  endtask

  task automatic send_fin(input logic [127:0] t);
    fin = 1;
    cyc();
    fin = 0;
    push_exp(t);
  endtask

  task automatic wait_tag();
    int k = 0;
    while (!tag_valid && k < 300) begin
      cyc();
      k++;
    end
    if (!tag_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_tag: tag_valid=0 after %0d cycles, required 1", k);
    end
    cyc();
  endtask

  localparam logic [127:0] H_TC = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] MASK_TC = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C_TC = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] TAG_TC2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d, padded;
    int s0, na, nc, fmode, total;
    logic [4:0] n;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    chk("rst_blk_ready", {127'b0, blk_ready}, 0);
    chk("rst_mul_start", {127'b0, mul_start}, 0);
    chk("rst_mul_block", mul_block, 0);
    chk("rst_mul_h", mul_h, 0);
    chk("rst_tag", tag, 0);
    chk("rst_tag_valid", {127'b0, tag_valid}, 0);
    chk("rst_error", {127'b0, error}, 0);
    blk_valid = 1;
    repeat (3) cyc();
    blk_valid = 0;
    chk("idle_blk_ready", {127'b0, blk_ready}, 0);

    // Empty message
    do_init(H_TC, MASK_TC);
    chk("mul_h_latched", mul_h, H_TC);
    send_fin(128'h0 ^ m_mask);
    wait_tag();

    // GCM test case 2
    do_init(H_TC, '0);
    send(C_TC, 5'd16, 1'b0, 1'b0);
    send_fin(TAG_TC2);
    wait_tag();

    // Partial block with garbage below the 5 valid bytes
    do_init(H_TC, '0);
    d = rnd128();
    padded = {d[127:88], 88'h0};
    send(d, 5'd5, 1'b0, 1'b0);
    send_fin(gf_mul(gf_mul(padded, H_TC) ^ {64'd0, 64'd40}, H_TC));
    wait_tag();

    // fin together with the final block accept
    do_init(rnd128(), rnd128());
    s0 = n_starts;
    send(rnd128(), 5'd16, 1'b0, 1'b1);
    wait_tag();
    chk("two_starts", 128'(n_starts - s0), 128'd2);

    // AAD after ciphertext is rejected without touching the hash
    do_init(rnd128(), rnd128());
    send(rnd128(), 5'd16, 1'b1, 1'b0);
    send(rnd128(), 5'd9, 1'b0, 1'b0);
    send(rnd128(), 5'd16, 1'b1, 1'b0);
    chk("aad_after_c_error", {127'b0, error}, 1);
    send_fin(model_tag());
    wait_tag();

    // Illegal byte counts
    do_init(rnd128(), rnd128());
    send(rnd128(), 5'd0, 1'b0, 1'b0);
    chk("bytes0_error", {127'b0, error}, 1);
    send(rnd128(), 5'd17, 1'b1, 1'b0);
    send(rnd128(), 5'd12, 1'b0, 1'b0);
    send_fin(model_tag());
    wait_tag();

    // init while the multiplier is busy: drain the stale result
    do_init(rnd128(), '0);
    lat_fix = 6;
    send(rnd128(), 5'd16, 1'b0, 1'b0);
    cyc();
    do_init(rnd128(), MASK_TC);
    lat_fix = 0;
    chk("drain_error", {127'b0, error}, 0);
    chk("drain_tag_valid", {127'b0, tag_valid}, 0);
    for (int k = 0; k < 20 && busy; k++) begin
      chk("drain_blk_ready", {127'b0, blk_ready}, 0);
      cyc();
    end
    chk("post_drain_ready", {127'b0, blk_ready}, 1);
    send_fin(128'h0 ^ m_mask);
    wait_tag();

    // Randomized messages
    for (int it = 0; it < 25; it++) begin
      do_init(rnd128(), rnd128());
      na = $urandom_range(0, 3);
      nc = $urandom_range(0, 3);
      total = na + nc;
      fmode = $urandom_range(0, 2);
      for (int j = 0; j < total; j++) begin
        n = 5'($urandom_range(1, 16));
        if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd17;
        send(rnd128(), n, j < na, (j == total - 1) && fmode == 0);
      end
      if (total == 0 || fmode != 0) begin
        if (fmode == 2) wait_ready();
        send_fin(model_tag());
      end
      wait_tag();
    end

    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
